// File: rtl/grid_pixel_gen.sv
// grid_pixel_gen: 2-stage pixel compositor (scan position, mouse sprite, canvas, glyph, edit cursor and selection in; pixel_color/pixel_valid out)
module grid_pixel_gen #(
  parameter int CELL_LOG2 = 5,
  parameter int H_BITS = 10,
  parameter int V_BITS = 9,
  parameter int BLINK_FRAMES = 30,
  parameter logic [11:0] GRID_COLOR = 12'h333,
  parameter logic [11:0] CUR_COLOR = 12'h0df,
  parameter logic [11:0] FG_COLOR = 12'hddd,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter logic [11:0] SEL_COLOR = 12'h024,
  localparam int CX_W = H_BITS - CELL_LOG2,
  localparam int CY_W = V_BITS - CELL_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              frame_start,
  input  logic [H_BITS-1:0] h_cnt,
  input  logic [V_BITS-1:0] v_cnt,
  input  logic              mouse_en,
  input  logic [11:0]       mouse_pixel,
  input  logic              canvas_pixel,
  input  logic              word_en,
  input  logic              word_pixel,
  input  logic              editing,
  input  logic [CX_W-1:0]   edit_x,
  input  logic [CY_W-1:0]   edit_y,
  input  logic [H_BITS-1:0] mouse_x,
  input  logic [V_BITS-1:0] mouse_y,
  input  logic              sel_start,
  input  logic              sel_clear,
  output logic [11:0]       pixel_color,
  output logic              pixel_valid
);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES > 0 ? BLINK_FRAMES - 1 : 0);
  logic [CX_W-1:0] cx, mcx, ax, sx_lo, sx_hi;
  logic [CY_W-1:0] cy, mcy, ay, sy_lo, sy_hi;
  logic [CELL_LOG2-1:0] ph, pv;
  logic [BW-1:0] blink_cnt;
  logic blink_on, edit_q, sel_active, edit_rise;
  logic border, in_edit, in_mouse, in_sel;
  logic v1, me1, cp1, we1, wp1, ed1, bo1, b1, ie1, im1, is1;
  logic [11:0] mp1, color;
  assign cx = h_cnt[H_BITS-1:CELL_LOG2];
  assign cy = v_cnt[V_BITS-1:CELL_LOG2];
  assign mcx = mouse_x[H_BITS-1:CELL_LOG2];
  assign mcy = mouse_y[V_BITS-1:CELL_LOG2];
  assign ph = h_cnt[CELL_LOG2-1:0];
  assign pv = v_cnt[CELL_LOG2-1:0];
  assign sx_lo = ax < mcx ? ax : mcx;
  assign sx_hi = ax < mcx ? mcx : ax;
  assign sy_lo = ay < mcy ? ay : mcy;
  assign sy_hi = ay < mcy ? mcy : ay;
  assign edit_rise = editing & ~edit_q;
  assign border = ~|ph | &ph | ~|pv | &pv;
  assign in_edit = cx == edit_x && cy == edit_y;
  assign in_mouse = cx == mcx && cy == mcy;
  assign in_sel = sel_active && cx >= sx_lo && cx <= sx_hi && cy >= sy_lo && cy <= sy_hi;
  always_comb begin
    color = !v1 ? 12'h000 :
            me1 ? mp1 :
            (ed1 && ie1) ? (b1 ? (bo1 ? CUR_COLOR : GRID_COLOR) : (cp1 ? FG_COLOR : BG_COLOR)) :
            b1 ? ((!ed1 && im1) ? CUR_COLOR : GRID_COLOR) :
            (we1 && wp1) ? FG_COLOR :
            (!ed1 && is1) ? SEL_COLOR : BG_COLOR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on <= 1'b1;
      edit_q <= 1'b0;
      sel_active <= 1'b0;
      ax <= '0;
      ay <= '0;
      {v1, me1, cp1, we1, wp1, ed1, bo1, b1, ie1, im1, is1} <= '0;
      mp1 <= '0;
      pixel_color <= '0;
      pixel_valid <= 1'b0;
    end else begin
      edit_q <= editing;
      if (edit_rise || BLINK_FRAMES == 0) begin
        blink_cnt <= '0;
        blink_on <= 1'b1;
      end else if (frame_start) begin
        blink_cnt <= blink_cnt == B_LAST ? '0 : blink_cnt + 1'b1;
        if (blink_cnt == B_LAST) blink_on <= ~blink_on;
      end
      if (sel_clear) sel_active <= 1'b0;
      else if (sel_start) begin
        ax <= mcx;
        ay <= mcy;
        sel_active <= 1'b1;
      end
      {v1, me1, cp1, we1, wp1, ed1, bo1} <= {valid, mouse_en, canvas_pixel, word_en, word_pixel, editing, blink_on};
      {b1, ie1, im1, is1} <= {border, in_edit, in_mouse, in_sel};
      mp1 <= mouse_pixel;
      pixel_color <= color;
      pixel_valid <= v1;
    end
  end
endmodule

// File: tb/tb_grid_pixel_gen.sv
// tb_grid_pixel_gen: table-driven and scoreboarded bench for grid_pixel_gen (32-px cells with 2-frame blink, plus a 16-px always-on instance)
module tb_grid_pixel_gen;
  logic clk = 0, rst = 1, valid = 0, frame_start = 0, mouse_en = 0, canvas_pixel = 0;
  logic word_en = 0, word_pixel = 0, editing = 0, sel_start = 0, sel_clear = 0;
  logic [9:0] h_cnt = 0, mouse_x = 0;
  logic [8:0] v_cnt = 0, mouse_y = 0;
  logic [11:0] mouse_pixel = 0;
  logic [4:0] edit_x = 0;
  logic [3:0] edit_y = 0;
  logic [5:0] edit_x4 = 0;
  logic [4:0] edit_y4 = 0;
  logic [11:0] pc5, pc4;
  logic pv5, pv4;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {
    string nm;
    int v, h, vc, me, mp, cp, we, wp, ed, ex, ey, ex4, ey4, mx, my, e5, c4, e4;
  } vec_t;
  typedef struct {
    int due, ev, e5, c4, e4;
    string nm;
  } sb_t;
  vec_t tv[$];
  sb_t sb[$];
  grid_pixel_gen #(.BLINK_FRAMES(2)) dut5 (
    .clk(clk), .rst(rst), .valid(valid), .frame_start(frame_start), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .mouse_en(mouse_en), .mouse_pixel(mouse_pixel), .canvas_pixel(canvas_pixel), .word_en(word_en),
    .word_pixel(word_pixel), .editing(editing), .edit_x(edit_x), .edit_y(edit_y), .mouse_x(mouse_x),
    .mouse_y(mouse_y), .sel_start(sel_start), .sel_clear(sel_clear), .pixel_color(pc5), .pixel_valid(pv5)
  );
  grid_pixel_gen #(.CELL_LOG2(4), .BLINK_FRAMES(0)) dut4 (
    .clk(clk), .rst(rst), .valid(valid), .frame_start(frame_start), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .mouse_en(mouse_en), .mouse_pixel(mouse_pixel), .canvas_pixel(canvas_pixel), .word_en(word_en),
    .word_pixel(word_pixel), .editing(editing), .edit_x(edit_x4), .edit_y(edit_y4), .mouse_x(mouse_x),
    .mouse_y(mouse_y), .sel_start(sel_start), .sel_clear(sel_clear), .pixel_color(pc4), .pixel_valid(pv4)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got valid=%0b color=%h, want valid=%0b color=%h", nm, act[12], act[11:0], exp[12], exp[11:0]);
    end
  endtask
  always @(negedge clk) begin : mon
    sb_t r;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      chk(r.nm, {pv5, pc5}, {1'(r.ev), 12'(r.e5)});
      if (r.c4 != 0) chk({r.nm, "_c4"}, {pv4, pc4}, {1'(r.ev), 12'(r.e4)});
    end
  end
  task automatic go(input int e5, input int c4, input int e4, input string nm);
    sb.push_back('{cyc + 2, int'(valid), e5, c4, e4, nm});
    @(negedge clk);
  endtask
  task automatic apply(input vec_t t);
    valid = 1'(t.v); h_cnt = 10'(t.h); v_cnt = 9'(t.vc); mouse_en = 1'(t.me); mouse_pixel = 12'(t.mp);
    canvas_pixel = 1'(t.cp); word_en = 1'(t.we); word_pixel = 1'(t.wp); editing = 1'(t.ed);
    edit_x = 5'(t.ex); edit_y = 4'(t.ey); edit_x4 = 6'(t.ex4); edit_y4 = 5'(t.ey4);
    mouse_x = 10'(t.mx); mouse_y = 9'(t.my);
  endtask
  task automatic bstep(input logic fs, input logic ed, input int e, input string nm);
    frame_start = fs;
    editing = ed;
    go(e, 0, 0, nm);
  endtask
  task automatic sstep(input int h, input int v, input int e, input string nm);
    h_cnt = 10'(h);
    v_cnt = 9'(v);
    go(e, 0, 0, nm);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end
  initial begin
    //                 v  h   v  me mp    cp we wp ed ex ey x4 y4 mx   my   e5     c4 e4
    tv.push_back('{"cursor_border",   1, 64, 70, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 70,  70,  'h0df, 0, 0});
    tv.push_back('{"grid_border",     1, 32, 70, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 70,  70,  'h333, 0, 0});
    tv.push_back('{"word_fg",         1, 70, 70, 0, 0,    0, 1, 1, 0, 0, 0, 0, 0, 70,  70,  'hddd, 0, 0});
    tv.push_back('{"word_off",        1, 70, 70, 0, 0,    0, 1, 0, 0, 0, 0, 0, 0, 70,  70,  'h000, 0, 0});
    tv.push_back('{"ones_border",     1, 95, 70, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 70,  70,  'h0df, 0, 0});
    tv.push_back('{"edit_fg",         1, 40, 40, 0, 0,    1, 0, 0, 1, 1, 1, 0, 0, 300, 300, 'hddd, 0, 0});
    tv.push_back('{"edit_bg",         1, 40, 40, 0, 0,    0, 0, 0, 1, 1, 1, 0, 0, 300, 300, 'h000, 0, 0});
    tv.push_back('{"edit_border",     1, 63, 40, 0, 0,    0, 0, 0, 1, 1, 1, 0, 0, 300, 300, 'h0df, 0, 0});
    tv.push_back('{"edit_mouse_grid", 1, 64, 70, 0, 0,    0, 0, 0, 1, 1, 1, 0, 0, 70,  70,  'h333, 0, 0});
    tv.push_back('{"mouse_prio",      1, 32, 40, 1, 'hf00, 0, 0, 0, 1, 1, 1, 0, 0, 300, 300, 'hf00, 0, 0});
    tv.push_back('{"invalid",         0, 32, 40, 1, 'hf00, 0, 0, 0, 1, 1, 1, 0, 0, 300, 300, 'h000, 0, 0});
    tv.push_back('{"edit_over_word",  1, 40, 40, 0, 0,    0, 1, 1, 1, 1, 1, 0, 0, 300, 300, 'h000, 0, 0});
    tv.push_back('{"word_noedit",     1, 40, 40, 0, 0,    0, 1, 1, 0, 1, 1, 0, 0, 300, 300, 'hddd, 0, 0});
    tv.push_back('{"h15",             1, 15, 40, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0,   0,   'h000, 1, 'h333});
    tv.push_back('{"h16",             1, 16, 40, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0,   0,   'h000, 1, 'h333});
    tv.push_back('{"edit4_in",        1, 33, 8,  0, 0,    1, 0, 0, 1, 0, 0, 2, 0, 300, 300, 'h000, 1, 'hddd});
    tv.push_back('{"edit4_edge",      1, 47, 8,  0, 0,    1, 0, 0, 1, 0, 0, 2, 0, 300, 300, 'h000, 1, 'h0df});
    tv.push_back('{"edit4_out",       1, 48, 8,  0, 0,    1, 0, 0, 1, 0, 0, 2, 0, 300, 300, 'h000, 1, 'h333});
    tv.push_back('{"edit4_before",    1, 31, 8,  0, 0,    1, 0, 0, 1, 0, 0, 2, 0, 300, 300, 'h0df, 1, 'h333});
    repeat (3) begin
      @(negedge clk);
      chk("reset", {pv5, pc5}, 13'h0);
      chk("reset_c4", {pv4, pc4}, 13'h0);
    end
    rst = 0; valid = 1; h_cnt = 33; v_cnt = 40;
    go('h000, 1, 'h000, "latency");
    chk("latency_early", {pv5, pc5}, 13'h0);
    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i]);
      go(tv[i].e5, tv[i].c4, tv[i].e4, tv[i].nm);
    end
    valid = 1; mouse_en = 0; word_en = 0; word_pixel = 0; canvas_pixel = 0;
    mouse_x = 300; mouse_y = 300; edit_x = 1; edit_y = 1; h_cnt = 32; v_cnt = 40;
    bstep(0, 0, 'h333, "blink_idle");
    bstep(0, 1, 'h0df, "blink_rise");
    bstep(1, 1, 'h0df, "blink_f1");
    bstep(1, 1, 'h0df, "blink_f2");
    bstep(0, 1, 'h333, "blink_off");
    bstep(1, 1, 'h333, "blink_f3");
    bstep(1, 1, 'h333, "blink_f4");
    bstep(0, 1, 'h0df, "blink_on_again");
    bstep(1, 1, 'h0df, "blink_f5");
    bstep(1, 1, 'h0df, "blink_f6");
    bstep(0, 1, 'h333, "blink_off2");
    bstep(0, 0, 'h333, "blink_drop");
    bstep(1, 1, 'h333, "blink_rise_fs");
    bstep(0, 1, 'h0df, "blink_restart_wins");
    frame_start = 0; editing = 0; mouse_x = 80; mouse_y = 40; sel_start = 1;
    sstep(80, 40, 'h000, "sel_anchor");
    sel_start = 0; mouse_x = 10; mouse_y = 100;
    sstep(10, 40, 'h024, "sel_0_1");
    sstep(80, 100, 'h024, "sel_2_3");
    sstep(48, 80, 'h024, "sel_1_2");
    sstep(112, 80, 'h000, "sel_3_2");
    sstep(10, 10, 'h000, "sel_0_0");
    sstep(80, 140, 'h000, "sel_2_4");
    editing = 1; edit_x = 9; edit_y = 9;
    sstep(48, 80, 'h000, "sel_hidden");
    editing = 0;
    sstep(48, 80, 'h024, "sel_retained");
    sel_start = 1; sel_clear = 1;
    sstep(10, 100, 'h024, "sel_clear_cycle");
    sel_start = 0; sel_clear = 0;
    sstep(10, 100, 'h000, "sel_cleared");
    word_en = 1; word_pixel = 1;
    sstep(70, 70, 'hddd, "pre_reset");
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (2) begin
      @(negedge clk);
      chk("mid_reset", {pv5, pc5}, 13'h0);
      chk("mid_reset_c4", {pv4, pc4}, 13'h0);
    end
    rst = 0;
    go('hddd, 0, 0, "post_reset");
    chk("post_reset_early", {pv5, pc5}, 13'h0);
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/grid_pixel_gen.md
# grid_pixel_gen

Parametrised, pipelined pixel compositor for the cell-grid editor display. It takes the VGA scan position, the mouse sprite, canvas and glyph layers, and the cursor and selection state, and produces one registered 12-bit colour per pixel with fixed 2-cycle latency. It adds three things to the combinational grid colour mux: a configurable cell size, a blinking edit-cell border, and a latched multi-cell selection rectangle. It sits between the VGA sync/address logic and the DAC output register.

## Interface
- CELL_LOG2, 5, log2 of cell edge in pixels (5 → 32×32 cells)
- H_BITS, 10, width of h_cnt; V_BITS, 9, width of v_cnt
- BLINK_FRAMES, 30, frames per blink half-period; 0 disables blinking (always on)
- GRID_COLOR 12'h333, CUR_COLOR 12'h0df, FG_COLOR 12'hddd, BG_COLOR 12'h000, SEL_COLOR 12'h024
- Derived: CX_W = H_BITS-CELL_LOG2, CY_W = V_BITS-CELL_LOG2
- Reset: synchronous, active-high; single clock domain.
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- valid  in  1  scan position inside the visible area
- frame_start  in  1  one-cycle pulse at the start of each frame
- h_cnt  in  H_BITS  / v_cnt  in  V_BITS  scan position
- mouse_en  in  1  / mouse_pixel  in  12  mouse sprite covers the pixel / sprite colour
- canvas_pixel  in  1  edit-cell canvas bit
- word_en  in  1  / word_pixel  in  1  glyph layer enable / glyph bit
- editing  in  1  edit mode
- edit_x  in  CX_W  / edit_y  in  CY_W  edit cell coordinates
- mouse_x  in  H_BITS  / mouse_y  in  V_BITS  mouse pixel position
- sel_start  in  1  pulse: latch the selection anchor
- sel_clear  in  1  pulse: drop the selection
- pixel_color  out  12  composited colour
- pixel_valid  out  1  valid delayed to align with pixel_color

## Operation
- Cell coordinates: cx = h_cnt[H_BITS-1:CELL_LOG2], cy = v_cnt[V_BITS-1:CELL_LOG2].
- Border pixel: the low CELL_LOG2 bits of h_cnt or v_cnt are all-zero or all-ones.
- Mouse cell: mcx = mouse_x[H_BITS-1:CELL_LOG2], mcy = mouse_y[V_BITS-1:CELL_LOG2].
- Blink state (blink_cnt, blink_on):
  - On frame_start: blink_cnt increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - On a rising edge of editing (editing sampled against its previous-cycle value): blink_cnt←0, blink_on←1.
  - If the editing rising edge and frame_start occur in the same cycle, the restart wins.
  - With BLINK_FRAMES=0, blink_on is held at 1.
- Selection state (sel_active, ax, ay):
  - sel_start: ax←mcx, ay←mcy, sel_active←1.
  - sel_clear: sel_active←0. If sel_start and sel_clear occur in the same cycle, sel_clear wins.
  - The selection rectangle is the cells with min(ax,mcx) ≤ cx ≤ max(ax,mcx) and min(ay,mcy) ≤ cy ≤ max(ay,mcy), inclusive. It tracks the live mouse position.
  - While editing=1 the selection is hidden but retained.
- Colour priority (first match wins):
  1. !valid → 0.
  2. mouse_en → mouse_pixel.
  3. editing and pixel in edit cell:
     - border pixel → CUR_COLOR if blink_on, else GRID_COLOR;
     - interior → FG_COLOR if canvas_pixel, else BG_COLOR.
  4. Border pixel → CUR_COLOR if !editing and pixel in mouse cell, else GRID_COLOR.
  5. word_en and word_pixel → FG_COLOR.
  6. !editing and sel_active and pixel in selection rectangle → SEL_COLOR.
  7. Otherwise BG_COLOR.
- All comparisons are unsigned at cell width; no arithmetic wraps.

## Timing
- Stage 1 (edge N+1) registers:
  - the decoded flags: border, in_edit, in_mouse_cell, in_sel, using state as it was before edge N+1;
  - valid, mouse_en, mouse_pixel, canvas_pixel, word_en, word_pixel, editing, blink_on.
- Stage 2 (edge N+2) registers pixel_color and pixel_valid.
- Latency: inputs sampled at edge N appear on the outputs after edge N+2. Throughput is 1 pixel per cycle; no stalls.
- State updates (blink, selection) take effect on the next pixel sampled; pixels already in the pipeline keep their captured flags.
- Reset:
  - pixel_color=0, pixel_valid=0, all pipeline registers 0;
  - blink_cnt=0, blink_on=1, sel_active=0, ax=ay=0, previous-editing register=0.
- Reset asserted mid-frame: outputs read 0 from the cycle after the reset edge until two cycles after rst deasserts.

## Test plan
- Reset/latency: hold rst 3 cycles, then drive valid=1 at h=33, v=40 with no layers active. Required: pixel_color=0 and pixel_valid=0 during reset; pixel_color=12'h000 and pixel_valid=1 exactly 2 cycles after the inputs are applied.
- Grid/cursor: editing=0, mouse at (70,70), scan h=64, v=70 → 12'h0df; scan h=32, v=70 → 12'h333; scan h=70, v=70, word_en=1, word_pixel=1 → 12'hddd.
- Blink (BLINK_FRAMES=2): raise editing with edit cell (1,1). Border pixel h=32, v=40 reads 12'h0df. After 2 frame_start pulses it reads 12'h333; after 2 more it reads 12'h0df. Pulse frame_start in the same cycle as a new editing rise: blink_on stays 1.
- Selection: mouse cell (2,1), sel_start; then move the mouse to cell (0,3). Interior pixels of cells (0..2, 1..3) read 12'h024 and cell (3,2) reads 12'h000. Assert sel_start and sel_clear together: the selection is gone.
- Priority: mouse_en=1, mouse_pixel=12'hf00 over an edit-cell border → 12'hf00. The same pixel with valid=0 → 0.
- CELL_LOG2=4 instance: h=15 and h=16 are both border pixels, and edit cell (2,0) covers h=32..47.
